// File: rtl/dec_stopwatch_ctrl.sv
// dec_stopwatch_ctrl: run/pause/idle sequencer for a cascaded BCD stopwatch.
// Prescaled tick, digit carry chain, lap capture and wrap-around overflow pulse.
`timescale 1ns/1ps
`default_nettype none

module dec_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*DIGITS-1:0] counter,
  output logic [4*DIGITS-1:0] lap_value,
  output logic                lap_valid,
  output logic                running,
  output logic                overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] cnt_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !stop && !clear) state_next = RUN;
      RUN: begin
        if (clear)     state_next = IDLE;
        else if (stop) state_next = PAUSE;
      end
      PAUSE: begin
        if (clear)                state_next = IDLE;
        else if (start && !stop)  state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  assign tick     = (state == RUN) && (presc == PRE_LAST);
  assign carry[0] = tick;

  // carry[i+1] is high when the tick ripples through digits 0..i, all at 9
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] d;
    assign d                  = counter[4*i +: 4];
    assign carry[i+1]         = carry[i] && (d == 4'd9);
    assign cnt_next[4*i +: 4] = !carry[i]    ? d :
                                (d == 4'd9)  ? 4'd0 : d + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      counter   <= '0;
      lap_value <= '0;
      lap_valid <= 1'b0;
      running   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state    <= state_next;
      running  <= (state_next == RUN);
      overflow <= 1'b0;
      if (clear) begin
        presc     <= '0;
        counter   <= '0;
        lap_value <= '0;
        lap_valid <= 1'b0;
      end else begin
        if (state == RUN)
          presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
        counter  <= cnt_next;
        overflow <= carry[DIGITS];
        // lap sees the pre-increment value when it coincides with a tick
        if (lap && state != IDLE) begin
          lap_value <= counter;
          lap_valid <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dec_stopwatch_ctrl.sv
// Directed bench for dec_stopwatch_ctrl: DIGITS=2 with TICK_DIV=4 and TICK_DIV=1.
`timescale 1ns/1ps
`default_nettype none

module tb_dec_stopwatch_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: DIGITS=2, TICK_DIV=4
  logic       reset, start, stop, clear, lap;
  logic [7:0] counter, lap_value;
  logic       lap_valid, running, overflow;

  // DUT B: DIGITS=2, TICK_DIV=1
  logic       b_reset, b_start, b_stop, b_clear, b_lap;
  logic [7:0] b_counter, b_lap_value;
  logic       b_lap_valid, b_running, b_overflow;

  int vectors  = 0;
  int miscompares = 0;

  dec_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .counter(counter), .lap_value(lap_value), .lap_valid(lap_valid),
    .running(running), .overflow(overflow)
  );

  dec_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(1)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .stop(b_stop), .clear(b_clear),
    .lap(b_lap), .counter(b_counter), .lap_value(b_lap_value),
    .lap_valid(b_lap_valid), .running(b_running), .overflow(b_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until counter first equals v (the edge that loaded it), bounded.
  task automatic wait_cnt(input logic [7:0] v);
    int n = 0;
    while (counter !== v && n < 2000) begin
      step();
      n++;
    end
    check("wait_cnt", {24'd0, counter}, {24'd0, v});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    b_reset = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_clear = 1'b0; b_lap = 1'b0;
    step(3);
    check("rst_counter",   counter,   8'h00);
    check("rst_running",   running,   1'b0);
    check("rst_lap_valid", lap_valid, 1'b0);
    check("rst_lap_value", lap_value, 8'h00);
    check("rst_overflow",  overflow,  1'b0);
    reset = 1'b0;

    // start -> RUN; first tick TICK_DIV cycles after entering RUN
    start = 1'b1; step(); start = 1'b0;
    check("run_running", running, 1'b1);
    check("run_cnt0",    counter, 8'h00);
    step(3);
    check("pre_tick",    counter, 8'h00);
    step();
    check("first_tick",  counter, 8'h01);
    step(4);
    check("second_tick", counter, 8'h02);

    // carry into digit 1
    wait_cnt(8'h09);
    step(3);
    check("hold_09", counter, 8'h09);
    step();
    check("carry_10", counter, 8'h10);

    // wrap 99 -> 00 with single-cycle overflow
    wait_cnt(8'h99);
    step(3);
    check("ovf_before", overflow, 1'b0);
    step();
    check("wrap_cnt", counter, 8'h00);
    check("ovf_pulse", overflow, 1'b1);
    step();
    check("ovf_after", overflow, 1'b0);
    check("still_run", running, 1'b1);

    // pause at 37 with prescaler landing on 2, then resume
    wait_cnt(8'h37);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    check("pause_running", running, 1'b0);
    step(20);
    check("pause_hold", counter, 8'h37);
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    check("pause_stopstart", running, 1'b0);
    check("pause_hold2", counter, 8'h37);
    start = 1'b1; step(); start = 1'b0;
    check("resume_running", running, 1'b1);
    step();
    check("resume_37", counter, 8'h37);
    step();
    check("resume_38", counter, 8'h38);

    // lap coinciding with the 52->53 tick captures 52
    wait_cnt(8'h52);
    step(3);
    lap = 1'b1; step(); lap = 1'b0;
    check("lap_tick_cnt", counter,   8'h53);
    check("lap_tick_val", lap_value, 8'h52);
    check("lap_valid",    lap_valid, 1'b1);
    step();
    lap = 1'b1; step(); lap = 1'b0;
    check("lap_plain_val", lap_value, 8'h53);
    check("lap_continue",  counter,   8'h53);

    // clear dominates stop/start/lap in RUN
    clear = 1'b1; stop = 1'b1; start = 1'b1; lap = 1'b1;
    step();
    clear = 1'b0; stop = 1'b0; start = 1'b0; lap = 1'b0;
    check("clr_running",   running,   1'b0);
    check("clr_counter",   counter,   8'h00);
    check("clr_lap_valid", lap_valid, 1'b0);
    check("clr_lap_value", lap_value, 8'h00);
    lap = 1'b1; stop = 1'b1; step(); lap = 1'b0; stop = 1'b0;
    check("idle_lap_ign",  lap_valid, 1'b0);
    check("idle_stop_ign", running,   1'b0);
    step(5);
    check("idle_hold", counter, 8'h00);

    // reset mid-RUN at 71
    start = 1'b1; step(); start = 1'b0;
    wait_cnt(8'h70);
    lap = 1'b1; step(); lap = 1'b0;
    check("pre_rst_lapv", lap_valid, 1'b1);
    wait_cnt(8'h71);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_counter",   counter,   8'h00);
    check("mid_rst_running",   running,   1'b0);
    check("mid_rst_lap_valid", lap_valid, 1'b0);
    check("mid_rst_lap_value", lap_value, 8'h00);
    step(6);
    check("mid_rst_idle", counter, 8'h00);

    // TICK_DIV=1: count every RUN cycle
    b_reset = 1'b0;
    b_start = 1'b1; step(); b_start = 1'b0;
    check("b_running", b_running, 1'b1);
    check("b_cnt0",    b_counter, 8'h00);
    step();
    check("b_cnt1",    b_counter, 8'h01);
    step();
    check("b_cnt2",    b_counter, 8'h02);
    step(97);
    check("b_cnt99",   b_counter, 8'h99);
    step();
    check("b_wrap",    b_counter, 8'h00);
    check("b_ovf",     b_overflow, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
